// File: rtl/pipelined_addsub.sv
// Carry-chunked pipelined adder/subtractor with valid/ready handshake and optional signed saturation.
// Stage k resolves chunk k; lower result chunks and upper operand chunks ride along in a skewed pipeline.
module pipelined_addsub #(
  parameter int WIDTH    = 16,
  parameter int STAGES   = 2,
  parameter int USE_CIN  = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = WIDTH / STAGES;

  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0 ||
      USE_CIN < 0 || USE_CIN > 1 || SATURATE < 0 || SATURATE > 1) begin : g_bad_param
    $error("pipelined_addsub: illegal parameter combination");
  end

  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic             advance_s;
  logic             accept_s;
  logic             ci_s;
  logic             c0_s;
  logic [WIDTH-1:0] bx_s;

  // Global stall: the whole pipe moves only when the output slot is free or being drained.
  assign advance_s = !out_valid_q || out_ready;
  assign in_ready  = advance_s;
  assign accept_s  = in_valid && advance_s;

  assign ci_s = (USE_CIN != 0) ? cin : 1'b0;
  assign bx_s = sub ? ~b : b;
  assign c0_s = sub ? ~ci_s : ci_s;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand B bits not yet consumed at this stage's input: chunks k and above.
    localparam int HW = WIDTH - k * CW;

    logic             vld_in_s;
    logic             cy_in_s;
    logic             as_in_s;
    logic             bs_in_s;
    logic [WIDTH-1:0] acc_in_s;
    logic [HW-1:0]    bx_in_s;
    logic [WIDTH-1:0] acc_d;
    logic             cy_d;

    if (k == 0) begin : g_src
      assign vld_in_s = accept_s;
      assign acc_in_s = a;
      assign bx_in_s  = bx_s;
      assign cy_in_s  = c0_s;
      assign as_in_s  = a[WIDTH-1];
      assign bs_in_s  = bx_s[WIDTH-1];
    end else begin : g_src
      assign vld_in_s = g_stage[k-1].g_reg.vld_q;
      assign acc_in_s = g_stage[k-1].g_reg.acc_q;
      assign bx_in_s  = g_stage[k-1].g_reg.bx_q;
      assign cy_in_s  = g_stage[k-1].g_reg.cy_q;
      assign as_in_s  = g_stage[k-1].g_reg.as_q;
      assign bs_in_s  = g_stage[k-1].g_reg.bs_q;
    end

    // acc holds finished result chunks below k and pending A chunks above k.
    always_comb begin
      acc_d = acc_in_s;
      {cy_d, acc_d[k*CW +: CW]} = {1'b0, acc_in_s[k*CW +: CW]}
                                + {1'b0, bx_in_s[CW-1:0]}
                                + {{CW{1'b0}}, cy_in_s};
    end

    if (k < STAGES - 1) begin : g_reg
      logic             vld_q;
      logic             cy_q;
      logic             as_q;
      logic             bs_q;
      logic [WIDTH-1:0] acc_q;
      logic [HW-CW-1:0] bx_q;

      // Inner stage register; data is only loaded for real beats.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_q <= 1'b0;
          cy_q  <= 1'b0;
          as_q  <= 1'b0;
          bs_q  <= 1'b0;
          acc_q <= {WIDTH{1'b0}};
          bx_q  <= {(HW-CW){1'b0}};
        end else if (advance_s) begin
          vld_q <= vld_in_s;
          if (vld_in_s) begin
            cy_q  <= cy_d;
            as_q  <= as_in_s;
            bs_q  <= bs_in_s;
            acc_q <= acc_d;
            bx_q  <= bx_in_s[HW-1:CW];
          end
        end
      end
    end else begin : g_out
      logic             ovf_s;
      logic [WIDTH-1:0] res_s;

      always_comb begin
        ovf_s = (as_in_s == bs_in_s) && (acc_d[WIDTH-1] != as_in_s);
        if ((SATURATE != 0) && ovf_s) begin
          res_s = as_in_s ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
          res_s = acc_d;
        end
      end

      // Output register; bubbles present all-zero data so idle outputs read as zero.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_valid_q <= 1'b0;
          sum_q       <= {WIDTH{1'b0}};
          cout_q      <= 1'b0;
          ovf_q       <= 1'b0;
        end else if (advance_s) begin
          out_valid_q <= vld_in_s;
          if (vld_in_s) begin
            sum_q  <= res_s;
            cout_q <= cy_d;
            ovf_q  <= ovf_s;
          end else begin
            sum_q  <= {WIDTH{1'b0}};
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
          end
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub: three configurations share one stimulus stream.
// dut_a: S=4 cin/wrap, dut_b: S=4 no-cin/saturate, dut_c: S=1 cin/wrap.
module tb_pipelined_addsub;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, out_ready, cin, sub;
  logic [W-1:0] a, b;

  logic in_ready_a, out_valid_a, cout_a, ovf_a;
  logic in_ready_b, out_valid_b, cout_b, ovf_b;
  logic in_ready_c, out_valid_c, cout_c, ovf_c;
  logic [W-1:0] sum_a, sum_b, sum_c;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(W), .STAGES(4), .USE_CIN(1), .SATURATE(0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid_a), .out_ready(out_ready),
    .sum(sum_a), .cout(cout_a), .ovf(ovf_a));

  pipelined_addsub #(.WIDTH(W), .STAGES(4), .USE_CIN(0), .SATURATE(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid_b), .out_ready(out_ready),
    .sum(sum_b), .cout(cout_b), .ovf(ovf_b));

  pipelined_addsub #(.WIDTH(W), .STAGES(1), .USE_CIN(1), .SATURATE(0)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid_c), .out_ready(out_ready),
    .sum(sum_c), .cout(cout_c), .ovf(ovf_c));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sa;  // cin used, wrap
    logic        ca;
    logic        oa;
    logic [15:0] sb;  // cin ignored, saturate
    logic        cb;
    logic        ob;
  } vec_t;

  vec_t vecs[12];
  logic [17:0] qa[$];
  logic [17:0] qb[$];
  logic [15:0] ra[20];
  logic [15:0] rb[20];
  logic        rc[20];
  logic        rs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] obs(input logic v, input logic [15:0] s, input logic c, input logic o);
    return {13'd0, v, s, c, o};
  endfunction

  // Behavioural reference: {sum, cout, ovf}
  function automatic logic [17:0] model(input logic [15:0] ia, input logic [15:0] ib, input logic icin,
                                        input logic isub, input logic use_cin, input logic sat);
    logic        ci, c0, o;
    logic [15:0] bx, s;
    logic [16:0] r;
    ci = use_cin ? icin : 1'b0;
    bx = isub ? ~ib : ib;
    c0 = isub ? ~ci : ci;
    r  = {1'b0, ia} + {1'b0, bx} + {16'd0, c0};
    o  = (ia[15] == bx[15]) && (r[15] != ia[15]);
    s  = r[15:0];
    if (sat && o) s = ia[15] ? 16'h8000 : 16'h7FFF;
    return {s, r[16], o};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[1]  = '{16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    vecs[3]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1};
    vecs[4]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1};
    vecs[5]  = '{16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0, 16'h000D, 1'b1, 1'b0};
    vecs[6]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1};
    vecs[8]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[9]  = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[10] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 16'hFFFE, 1'b1, 1'b0};
    vecs[11] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = 16'h0000; b = 16'h0000; cin = 1'b0; sub = 1'b0;

    // Reset state
    #1;
    check("reset_out_a", obs(out_valid_a, sum_a, cout_a, ovf_a), 32'd0);
    check("reset_out_b", obs(out_valid_b, sum_b, cout_b, ovf_b), 32'd0);
    check("reset_out_c", obs(out_valid_c, sum_c, cout_c, ovf_c), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_reset_in_ready", {29'd0, in_ready_a, in_ready_b, in_ready_c}, 32'h7);

    // Directed table, one isolated beat each, checking exact latency
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin; sub = vecs[i].sub; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check($sformatf("vec%0d_c_lat1", i), obs(out_valid_c, sum_c, cout_c, ovf_c),
            obs(1'b1, vecs[i].sa, vecs[i].ca, vecs[i].oa));
      check($sformatf("vec%0d_a_early1", i), {31'd0, out_valid_a}, 32'd0);
      repeat (2) @(negedge clk);
      #1;
      check($sformatf("vec%0d_a_early3", i), {31'd0, out_valid_a}, 32'd0);
      @(negedge clk);
      #1;
      check($sformatf("vec%0d_a", i), obs(out_valid_a, sum_a, cout_a, ovf_a),
            obs(1'b1, vecs[i].sa, vecs[i].ca, vecs[i].oa));
      check($sformatf("vec%0d_b", i), obs(out_valid_b, sum_b, cout_b, ovf_b),
            obs(1'b1, vecs[i].sb, vecs[i].cb, vecs[i].ob));
    end

    // Streaming with pseudo-random backpressure on the 4-stage configurations
    for (int i = 0; i < 20; i++) begin
      ra[i] = 16'($urandom); rb[i] = 16'($urandom);
      rc[i] = 1'($urandom); rs[i] = 1'($urandom);
    end
    ra[3] = 16'h7FFF; rb[3] = 16'h7FFF; rs[3] = 1'b0;
    begin
      int sent = 0;
      int got  = 0;
      for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
        @(negedge clk);
        out_ready = ($urandom_range(0, 2) != 0);
        if (sent < 20) begin
          in_valid = 1'b1; a = ra[sent]; b = rb[sent]; cin = rc[sent]; sub = rs[sent];
        end else begin
          in_valid = 1'b0;
        end
        #1;
        check("stream_in_ready_a", {31'd0, in_ready_a}, {31'd0, (!out_valid_a || out_ready)});
        check("stream_in_ready_b", {31'd0, in_ready_b}, {31'd0, (!out_valid_b || out_ready)});
        if (out_valid_a) begin
          if (qa.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL stream_a_extra: got unexpected beat sum %h expected none", sum_a);
          end else begin
            check("stream_a", obs(out_valid_a, sum_a, cout_a, ovf_a),
                  obs(1'b1, qa[0][17:2], qa[0][1], qa[0][0]));
            if (out_ready) begin
              void'(qa.pop_front());
              got++;
            end
          end
        end
        if (out_valid_b) begin
          if (qb.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL stream_b_extra: got unexpected beat sum %h expected none", sum_b);
          end else begin
            check("stream_b", obs(out_valid_b, sum_b, cout_b, ovf_b),
                  obs(1'b1, qb[0][17:2], qb[0][1], qb[0][0]));
            if (out_ready) void'(qb.pop_front());
          end
        end
        if (in_valid && in_ready_a) begin
          qa.push_back(model(a, b, cin, sub, 1'b1, 1'b0));
          qb.push_back(model(a, b, cin, sub, 1'b0, 1'b1));
          sent++;
        end
      end
      in_valid = 1'b0;
      check("stream_count", got, 32'd20);
      check("stream_a_left", qa.size(), 32'd0);
      check("stream_b_left", qb.size(), 32'd0);
    end

    // Reset in the middle of a stream
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = 16'h0100 + 16'(i); b = 16'h0011; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("midrst_first_beat", obs(out_valid_a, sum_a, cout_a, ovf_a), obs(1'b1, 16'h0111, 1'b0, 1'b0));
    rst = 1'b1;
    #1;
    check("midrst_async_a", obs(out_valid_a, sum_a, cout_a, ovf_a), 32'd0);
    check("midrst_async_b", obs(out_valid_b, sum_b, cout_b, ovf_b), 32'd0);
    check("midrst_in_ready", {31'd0, in_ready_a}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("midrst_no_stale_a%0d", i), obs(out_valid_a, sum_a, cout_a, ovf_a), 32'd0);
      check($sformatf("midrst_no_stale_b%0d", i), obs(out_valid_b, sum_b, cout_b, ovf_b), 32'd0);
    end
    @(negedge clk);
    a = 16'h00F0; b = 16'h0010; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("postrst_early", {31'd0, out_valid_a}, 32'd0);
    @(negedge clk);
    #1;
    check("postrst_beat_a", obs(out_valid_a, sum_a, cout_a, ovf_a), obs(1'b1, 16'h0101, 1'b0, 1'b0));
    check("postrst_beat_b", obs(out_valid_b, sum_b, cout_b, ovf_b), obs(1'b1, 16'h0100, 1'b0, 1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
